pkt_rr_arb: RTL and testbench

//  Packet-level round-robin arbiter for a router output port. Shares one output stream between

---
 rtl/pkt_rr_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_pkt_rr_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_arb.sv
// ----------------------------------------------------------------------------
// pkt_rr_arb
// Packet-level round-robin arbiter for one router output port.
//
// CLIENTS input streams share a single output stream. Arbitration happens
// in IDLE: the request search starts just after the previous winner. The
// winner is then locked in (LOCK) until the last beat of its packet is
// accepted. After that, one idle bubble cycle separates consecutive packets.
//
// Optional feature (compile-time macro PKT_RR_ARB_WDOG_EN):
//   A per-packet beat watchdog. If MAX_BEATS beats are accepted without a
//   last beat, the lock is released and wdog_err pulses for one cycle.
//   Without the macro, packets may be of any length and wdog_err is 0.
// ----------------------------------------------------------------------------
module pkt_rr_arb #(
    parameter int CLIENTS   = 2,
    parameter int WIDTH     = 32,
    parameter int SEL_W     = 1,
    parameter int MAX_BEATS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CLIENTS-1:0]         in_valid,
    input  logic [CLIENTS-1:0]         in_last,
    input  logic [CLIENTS*WIDTH-1:0]   in_data,
    output logic [CLIENTS-1:0]         in_ready,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [SEL_W-1:0]           gnt_id,
    output logic                       wdog_err
);

    // ------------------------------------------------------------------------
    // Parameter sanity (elaboration time only)
    // ------------------------------------------------------------------------
    generate
        if (CLIENTS < 2 || (1 << SEL_W) < CLIENTS || MAX_BEATS < 1) begin : g_bad_params
            $error("pkt_rr_arb: need CLIENTS>=2, 2**SEL_W>=CLIENTS, MAX_BEATS>=1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0]   LAST_CLIENT = SEL_W'(CLIENTS - 1);
    localparam logic [CLIENTS-1:0] ONE_C       = CLIENTS'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   sel_next;
    logic [SEL_W-1:0]   prev_winner_reg;
    logic [SEL_W-1:0]   prev_winner_next;
    logic               wdog_err_reg;
    logic               wdog_err_next;

    // While reset is asserted, every output is forced quiet, even if the
    // registers still hold a stale LOCK.
    logic               lock_active;
    assign lock_active = (state_reg == LOCK) && !reset;

    // ------------------------------------------------------------------------
    // Rotating-priority pick
    //   hi_mask selects the clients strictly above the previous winner. If
    //   any of those are requesting, the lowest one wins. Otherwise, the
    //   search wraps around and the lowest requesting client overall wins.
    // ------------------------------------------------------------------------
    logic [CLIENTS-1:0] hi_mask;
    logic [CLIENTS-1:0] req_hi;
    logic [CLIENTS-1:0] req_pick;
    logic [CLIENTS-1:0] pick_onehot;
    logic [SEL_W-1:0]   pick_id;
    logic [CLIENTS-1:0] id_mask [SEL_W];

    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_hi_mask
            assign hi_mask[gi] = (SEL_W'(gi) > prev_winner_reg);
        end
    endgenerate

    assign req_hi      = in_valid & hi_mask;
    assign req_pick    = (|req_hi) ? req_hi : in_valid;
    // Isolate the lowest set bit: x & (-x)
    assign pick_onehot = req_pick & (~req_pick + ONE_C);

    // One-hot to binary: bit gb of the index is the OR of all clients
    // whose index has bit gb set.
    generate
        for (genvar gb = 0; gb < SEL_W; gb++) begin : g_id_bit
            for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_id_client
                assign id_mask[gb][gi] = (((gi >> gb) & 1) == 1);
            end
            assign pick_id[gb] = |(pick_onehot & id_mask[gb]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Selected-client pass-through (AND-OR mux, one-hot select)
    // ------------------------------------------------------------------------
    logic [CLIENTS-1:0] sel_onehot;
    logic [CLIENTS-1:0] data_col [WIDTH];
    logic [WIDTH-1:0]   sel_data;
    logic               sel_valid;
    logic               sel_last;

    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_sel_onehot
            assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
        end
        // Transpose the data bus so that each output bit is a reduction
        // across clients.
        for (genvar wb = 0; wb < WIDTH; wb++) begin : g_data_bit
            for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_data_client
                assign data_col[wb][gi] = in_data[gi*WIDTH + wb];
            end
            assign sel_data[wb] = |(data_col[wb] & sel_onehot);
        end
    endgenerate

    assign sel_valid = |(in_valid & sel_onehot);
    assign sel_last  = |(in_last  & sel_onehot);

    // A beat of the locked packet moves this cycle
    logic accept;
    assign accept = lock_active && sel_valid && out_ready;

    // ------------------------------------------------------------------------
    // Optional beat watchdog
    // ------------------------------------------------------------------------
    logic wdog_trip;

`ifdef PKT_RR_ARB_WDOG_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_reg;
    logic [CNT_W-1:0] beat_cnt_next;

    // The MAX_BEATS-th accepted beat without in_last releases the lock.
    // A last beat on that same beat counts as normal completion.
    assign wdog_trip = accept && !sel_last &&
                       (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));

    // Beat counter: held at zero in IDLE, so it is clear on entry to LOCK
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (state_reg == IDLE) begin
            beat_cnt_next = '0;
        end else if (accept) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
    end

    // Beat counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_reg <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    // Choose the next state, the next locked client, and when to rotate priority
    always_comb begin
        state_next       = state_reg;
        sel_next         = sel_reg;
        prev_winner_next = prev_winner_reg;
        wdog_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|in_valid) begin
                    state_next = LOCK;
                    sel_next   = pick_id;
                end
            end
            LOCK: begin
                // Priority rotates only when the packet ends: either on its
                // last beat or on a watchdog release.
                if (accept && (sel_last || wdog_trip)) begin
                    state_next       = IDLE;
                    prev_winner_next = sel_reg;
                    wdog_err_next    = wdog_trip;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM and arbitration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            prev_winner_reg <= LAST_CLIENT;
            wdog_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sel_reg         <= sel_next;
            prev_winner_reg <= prev_winner_next;
            wdog_err_reg    <= wdog_err_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Pass the locked client through. Everything is quiet in IDLE and during reset.
    always_comb begin
        busy      = lock_active;
        gnt_id    = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        wdog_err  = wdog_err_reg && !reset;
        if (lock_active) begin
            gnt_id    = sel_reg;
            out_valid = sel_valid;
            out_last  = sel_last;
            out_data  = sel_data;
            in_ready  = sel_onehot & {CLIENTS{out_ready}};
        end
    end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_pkt_rr_arb
// Directed, table-driven bench for pkt_rr_arb with 4 clients.
// Client i drives data {i[7:0], beat[7:0]}. As a result, out_data shows both
// which client was passed through and which beat.
// Watchdog expectations follow PKT_RR_ARB_WDOG_EN (MAX_BEATS=4 here).
// ----------------------------------------------------------------------------
module tb_pkt_rr_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_last;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [1:0]  gnt_id;
    logic        wdog_err;

    pkt_rr_arb #(
        .CLIENTS   (4),
        .WIDTH     (16),
        .SEL_W     (2),
        .MAX_BEATS (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .wdog_err  (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        ord;
        logic [7:0]  beat;
        logic        busy;
        logic [1:0]  gnt;
        logic [3:0]  rdy;
        logic        ov;
        logic        ol;
        logic [15:0] od;
        logic        werr;
    } vec_t;

    vec_t tbl [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                input logic ord, input logic [7:0] beat,
                                input logic e_busy, input logic [1:0] e_gnt,
                                input logic [3:0] e_rdy, input logic e_ov, input logic e_ol,
                                input logic [15:0] e_od, input logic e_werr);
        vec_t r;
        r.rst = rst;  r.v = v;  r.l = l;  r.ord = ord;  r.beat = beat;
        r.busy = e_busy;  r.gnt = e_gnt;  r.rdy = e_rdy;  r.ov = e_ov;
        r.ol = e_ol;  r.od = e_od;  r.werr = e_werr;
        return r;
    endfunction

    // Idle expectation: every output is 0
    function automatic vec_t mk_idle(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                     input logic [7:0] beat, input logic e_werr);
        return mk(rst, v, l, 1'b1, beat, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 16'h0000, e_werr);
    endfunction

    // Drive one cycle's inputs shortly after the rising edge, check mid-cycle,
    // then advance to the next edge.
    task automatic run_vec(input vec_t t, input string name);
        logic [25:0] act;
        logic [25:0] exp;
        reset     = t.rst;
        in_valid  = t.v;
        in_last   = t.l;
        out_ready = t.ord;
        in_data   = {8'd3, t.beat, 8'd2, t.beat, 8'd1, t.beat, 8'd0, t.beat};
        #3;
        act = {busy, gnt_id, in_ready, out_valid, out_last, out_data, wdog_err};
        exp = {t.busy, t.gnt, t.rdy, t.ov, t.ol, t.od, t.werr};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%b gnt=%0d rdy=%b ov=%b ol=%b od=%h werr=%b, want busy=%b gnt=%0d rdy=%b ov=%b ol=%b od=%h werr=%b",
                     name, busy, gnt_id, in_ready, out_valid, out_last, out_data, wdog_err,
                     t.busy, t.gnt, t.rdy, t.ov, t.ol, t.od, t.werr);
        end else begin
            $display("ok   %s: busy=%b gnt=%0d rdy=%b ov=%b ol=%b od=%h werr=%b",
                     name, busy, gnt_id, in_ready, out_valid, out_last, out_data, wdog_err);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Vector table -------------------------------------------------
        // Test 1: reset, clients 0 and 1 both requesting -> 0 first, then 1
        tbl.push_back(mk_idle(1, 4'b0011, 4'b0000, 8'd0, 0));
        tbl.push_back(mk_idle(0, 4'b0011, 4'b0000, 8'd0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0001, 1, 8'd1, 1, 2'd0, 4'b0001, 1, 1, 16'h0001, 0));
        tbl.push_back(mk_idle(0, 4'b0011, 4'b0000, 8'd2, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0010, 1, 8'd3, 1, 2'd1, 4'b0010, 1, 1, 16'h0103, 0));
        tbl.push_back(mk_idle(0, 4'b0000, 4'b0000, 8'd0, 0));
        // Test 2: client 1 alone, 4 beats in order, then busy drops
        tbl.push_back(mk_idle(0, 4'b0010, 4'b0000, 8'd0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'd1, 1, 2'd1, 4'b0010, 1, 0, 16'h0101, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'd2, 1, 2'd1, 4'b0010, 1, 0, 16'h0102, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'd3, 1, 2'd1, 4'b0010, 1, 0, 16'h0103, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'd4, 1, 2'd1, 4'b0010, 1, 1, 16'h0104, 0));
        tbl.push_back(mk_idle(0, 4'b0000, 4'b0000, 8'd0, 0));
        // Test 3: reset, all four request 1-beat packets -> 0,1,2,3,0 every 2 cycles
        tbl.push_back(mk_idle(1, 4'b0000, 4'b0000, 8'd0, 0));
        tbl.push_back(mk_idle(0, 4'b1111, 4'b1111, 8'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'd0, 1, 2'd0, 4'b0001, 1, 1, 16'h0000, 0));
        tbl.push_back(mk_idle(0, 4'b1111, 4'b1111, 8'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'd0, 1, 2'd1, 4'b0010, 1, 1, 16'h0100, 0));
        tbl.push_back(mk_idle(0, 4'b1111, 4'b1111, 8'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'd0, 1, 2'd2, 4'b0100, 1, 1, 16'h0200, 0));
        tbl.push_back(mk_idle(0, 4'b1111, 4'b1111, 8'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'd0, 1, 2'd3, 4'b1000, 1, 1, 16'h0300, 0));
        tbl.push_back(mk_idle(0, 4'b1111, 4'b1111, 8'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'd0, 1, 2'd0, 4'b0001, 1, 1, 16'h0000, 0));
        // Test 4: client 2, 3 beats with out_ready toggling, valid gap, client 0 ignored
        tbl.push_back(mk_idle(0, 4'b0100, 4'b0000, 8'd0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'd1, 1, 2'd2, 4'b0100, 1, 0, 16'h0201, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'd9, 1, 2'd2, 4'b0100, 0, 0, 16'h0209, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 0, 8'd2, 1, 2'd2, 4'b0000, 1, 0, 16'h0202, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 1, 8'd2, 1, 2'd2, 4'b0100, 1, 0, 16'h0202, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 0, 8'd3, 1, 2'd2, 4'b0000, 1, 1, 16'h0203, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 1, 8'd3, 1, 2'd2, 4'b0100, 1, 1, 16'h0203, 0));
        tbl.push_back(mk_idle(0, 4'b0001, 4'b0001, 8'd0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'd0, 1, 2'd0, 4'b0001, 1, 1, 16'h0000, 0));

        reset = 1'b1;  in_valid = '0;  in_last = '0;  in_data = '0;  out_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // ---- Test 5: reset on beat 2 of a client-2 packet ----------------
        // prev_winner is 0 here. After reset, it must be 3, so {0,1} -> 0 wins.
        run_vec(mk_idle(0, 4'b0100, 4'b0000, 8'd0, 0), "rst_mid_idle");
        run_vec(mk(0, 4'b0100, 4'b0000, 1, 8'd1, 1, 2'd2, 4'b0100, 1, 0, 16'h0201, 0), "rst_mid_beat1");
        run_vec(mk_idle(1, 4'b0100, 4'b0000, 8'd2, 0), "rst_mid_during");
        run_vec(mk_idle(0, 4'b0011, 4'b0001, 8'd3, 0), "rst_mid_after");
        run_vec(mk(0, 4'b0011, 4'b0001, 1, 8'd4, 1, 2'd0, 4'b0001, 1, 1, 16'h0004, 0), "rst_mid_prev");

        // ---- Test 6: 6-beat packet on client 1, client 2 waiting ---------
        run_vec(mk_idle(0, 4'b0110, 4'b0000, 8'd0, 0), "long_idle");
        for (int b = 1; b <= 4; b++) begin
            run_vec(mk(0, 4'b0110, 4'b0000, 1, 8'(b), 1, 2'd1, 4'b0010, 1, 0, {8'd1, 8'(b)}, 0),
                    $sformatf("long_beat%0d", b));
        end
`ifdef PKT_RR_ARB_WDOG_EN
        // Lock released after beat 4. Beat 5 is not accepted, and the error pulses.
        run_vec(mk_idle(0, 4'b0110, 4'b0000, 8'd5, 1), "long_wdog");
`else
        run_vec(mk(0, 4'b0110, 4'b0000, 1, 8'd5, 1, 2'd1, 4'b0010, 1, 0, 16'h0105, 0), "long_beat5");
        run_vec(mk(0, 4'b0110, 4'b0010, 1, 8'd6, 1, 2'd1, 4'b0010, 1, 1, 16'h0106, 0), "long_beat6");
        run_vec(mk_idle(0, 4'b0110, 4'b0000, 8'd0, 0), "long_done");
`endif
        run_vec(mk(0, 4'b0100, 4'b0100, 1, 8'd7, 1, 2'd2, 4'b0100, 1, 1, 16'h0207, 0), "long_next");
        run_vec(mk_idle(0, 4'b0000, 4'b0000, 8'd0, 0), "long_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
